image_affine_streamer: RTL

- Successor to the frame-encoder rotator stage. Rasters an IMAGE_SIZE x IMAGE_SIZE destination sprite and inverse-maps each destination pixel through a caller-supplied rotation (cos/sin), with optional H/V mirroring.
- Fetches the source colour through a 1-cycle-latency SRAM read port instead of a full combinational LUT array.
- Streams pixels to the frame encoder over a valid/ready handshake with full backpressure.
- Sits between the sprite SRAM and the frame composer. One instance per object layer.

---
 rtl/image_affine_streamer.sv | 217 +++++++++++++++++++++
 1 files changed

// File: rtl/image_affine_streamer.sv
// Sprite rotator/mirror stage: rasters destination pixels, inverse-maps them through
// cos/sin into the sprite SRAM and streams colour indices out over valid/ready.
module image_affine_streamer #(
  parameter int unsigned IMAGE_SIZE  = 32,
  parameter int unsigned COOR_WIDTH  = 5,
  parameter int unsigned COLOR_WIDTH = 4,
  parameter int unsigned TRIG_WIDTH  = 10,
  parameter int unsigned FRAC_BITS   = 8
) (
  input  logic                         i_clk,
  input  logic                         i_rst_n,
  input  logic                         i_start,
  input  logic signed [TRIG_WIDTH-1:0] i_cos,
  input  logic signed [TRIG_WIDTH-1:0] i_sin,
  input  logic                         i_flip_h,
  input  logic                         i_flip_v,
  output logic                         o_rd_en,
  output logic [2*COOR_WIDTH-1:0]      o_rd_addr,
  input  logic [COLOR_WIDTH-1:0]       i_rd_data,
  output logic                         o_valid,
  input  logic                         i_ready,
  output logic [COLOR_WIDTH-1:0]       o_pixel,
  output logic                         o_opacity,
  output logic [COOR_WIDTH-1:0]        o_H,
  output logic [COOR_WIDTH-1:0]        o_V,
  output logic                         o_last,
  output logic                         o_busy,
  output logic                         o_done
);

  localparam int unsigned D_W   = COOR_WIDTH + 2;
  localparam int unsigned P_W   = TRIG_WIDTH + COOR_WIDTH + 3;
  localparam int unsigned SHIFT = FRAC_BITS + 1;
  localparam logic [COOR_WIDTH-1:0] C_MAX  = COOR_WIDTH'(IMAGE_SIZE - 1);
  localparam logic signed [D_W-1:0] CENTRE = D_W'(IMAGE_SIZE - 1);
  localparam logic signed [P_W-1:0] BIAS   = P_W'(IMAGE_SIZE << FRAC_BITS);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2
  } state_t;

  state_t state_q, state_d;

  logic                         en;
  logic                         last_hs_c;
  logic                         cnt_last_c;

  logic signed [TRIG_WIDTH-1:0] cfg_cos, cfg_sin;
  logic                         cfg_flip_h, cfg_flip_v;
  logic [COOR_WIDTH-1:0]        cnt_h, cnt_v;

  logic                         s1_valid;
  logic signed [D_W-1:0]        s1_dx, s1_dy;
  logic [COOR_WIDTH-1:0]        s1_h, s1_v;

  logic                         s2_valid;
  logic signed [P_W-1:0]        s2_sx, s2_sy;
  logic [COOR_WIDTH-1:0]        s2_h, s2_v;

  logic signed [P_W-1:0]        src_h_c, src_v_c;
  logic [COOR_WIDTH-1:0]        bits_h_c, bits_v_c, addr_h_c, addr_v_c;
  logic                         out_c;

  logic                         s3_valid, s3_out;
  logic [COOR_WIDTH-1:0]        s3_h, s3_v;
  logic [2*COOR_WIDTH-1:0]      s3_addr;

  logic                         s4_valid, s4_out;
  logic [COOR_WIDTH-1:0]        s4_h, s4_v;
  logic                         rd_pend;
  logic [COLOR_WIDTH-1:0]       hold;
  logic [COLOR_WIDTH-1:0]       pix_c;

  assign en         = !o_valid || i_ready;
  assign last_hs_c  = o_valid && i_ready && o_last;
  assign cnt_last_c = (cnt_h == C_MAX) && (cnt_v == C_MAX);
  assign o_busy     = (state_q != S_IDLE);
  assign o_rd_en    = en && s3_valid && !s3_out;
  assign o_rd_addr  = s3_addr;

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) state_q <= S_IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (i_start) state_d = S_RUN;
      S_RUN:   if (en && cnt_last_c) state_d = S_DRAIN;
      S_DRAIN: if (last_hs_c) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Frame configuration and raster issue counter
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      cfg_cos    <= '0;
      cfg_sin    <= '0;
      cfg_flip_h <= 1'b0;
      cfg_flip_v <= 1'b0;
      cnt_h      <= '0;
      cnt_v      <= '0;
      o_done     <= 1'b0;
    end else begin
      o_done <= (state_q == S_DRAIN) && last_hs_c;
      if ((state_q == S_IDLE) && i_start) begin
        cfg_cos    <= i_cos;
        cfg_sin    <= i_sin;
        cfg_flip_h <= i_flip_h;
        cfg_flip_v <= i_flip_v;
        cnt_h      <= '0;
        cnt_v      <= '0;
      end else if ((state_q == S_RUN) && en) begin
        cnt_h <= cnt_h + COOR_WIDTH'(1);
        if (cnt_h == C_MAX) cnt_v <= cnt_v + COOR_WIDTH'(1);
      end
    end
  end

  // S1/S2: centre the doubled coordinate, then rotate at full precision
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      s1_valid <= 1'b0;
      s1_dx    <= '0;
      s1_dy    <= '0;
      s1_h     <= '0;
      s1_v     <= '0;
      s2_valid <= 1'b0;
      s2_sx    <= '0;
      s2_sy    <= '0;
      s2_h     <= '0;
      s2_v     <= '0;
    end else if (en) begin
      s1_valid <= (state_q == S_RUN);
      s1_dx    <= $signed({1'b0, cnt_h, 1'b0}) - CENTRE;
      s1_dy    <= $signed({1'b0, cnt_v, 1'b0}) - CENTRE;
      s1_h     <= cnt_h;
      s1_v     <= cnt_v;
      s2_valid <= s1_valid;
      s2_sx    <= (P_W'(cfg_cos) * P_W'(s1_dx)) + (P_W'(cfg_sin) * P_W'(s1_dy));
      s2_sy    <= (P_W'(cfg_cos) * P_W'(s1_dy)) - (P_W'(cfg_sin) * P_W'(s1_dx));
      s2_h     <= s1_h;
      s2_v     <= s1_v;
    end
  end

  // Back to source pixel units; any bit above the coordinate field means out of range
  always_comb begin
    src_h_c  = (s2_sx + BIAS) >>> SHIFT;
    src_v_c  = (s2_sy + BIAS) >>> SHIFT;
    out_c    = (src_h_c[P_W-1:COOR_WIDTH] != '0) || (src_v_c[P_W-1:COOR_WIDTH] != '0);
    bits_h_c = src_h_c[COOR_WIDTH-1:0];
    bits_v_c = src_v_c[COOR_WIDTH-1:0];
    addr_h_c = cfg_flip_h ? (C_MAX - bits_h_c) : bits_h_c;
    addr_v_c = cfg_flip_v ? (C_MAX - bits_v_c) : bits_v_c;
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      s3_valid <= 1'b0;
      s3_out   <= 1'b0;
      s3_h     <= '0;
      s3_v     <= '0;
      s3_addr  <= '0;
      s4_valid <= 1'b0;
      s4_out   <= 1'b0;
      s4_h     <= '0;
      s4_v     <= '0;
    end else if (en) begin
      s3_valid <= s2_valid;
      s3_out   <= out_c;
      s3_h     <= s2_h;
      s3_v     <= s2_v;
      s3_addr  <= {addr_v_c, addr_h_c};
      s4_valid <= s3_valid;
      s4_out   <= s3_out;
      s4_h     <= s3_h;
      s4_v     <= s3_v;
    end
  end

  // Read data lands one cycle after the strobe whether or not the pipe moves
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      rd_pend <= 1'b0;
      hold    <= '0;
    end else begin
      rd_pend <= o_rd_en;
      if (rd_pend) hold <= i_rd_data;
    end
  end

  assign pix_c = s4_out ? '0 : (rd_pend ? i_rd_data : hold);

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      o_valid   <= 1'b0;
      o_pixel   <= '0;
      o_opacity <= 1'b0;
      o_H       <= '0;
      o_V       <= '0;
      o_last    <= 1'b0;
    end else if (en) begin
      o_valid   <= s4_valid;
      o_pixel   <= pix_c;
      o_opacity <= !s4_out && (pix_c != '0);
      o_H       <= s4_h;
      o_V       <= s4_v;
      o_last    <= s4_valid && (s4_h == C_MAX) && (s4_v == C_MAX);
    end
  end

endmodule
